// File: rtl/instrs_buff.sv
// instrs_buff
// Circular instruction FIFO sitting between the fetch stage and the decoder.
// It stores instruction/PC pairs so that fetch stalls and decode stalls are
// decoupled, and it empties completely on a pipeline reload (flush).
//
// Ports:
//   clk          single clock, all state changes on its rising edge
//   rst          synchronous active-high reset
//   flush        pipeline reload, empties the buffer (highest priority)
//   in_valid     fetch offers an entry
//   in_ready     buffer can accept an entry this cycle
//   in_instr     fetched instruction
//   in_pc        PC of the fetched instruction
//   out_valid    head entry is available to decode
//   out_ready    decode consumes the head entry
//   out_instr    instruction at head (don't-care when out_valid = 0)
//   out_pc       PC at head (don't-care when out_valid = 0)
//   perf_head    read pointer, zero-extended to 8 bits
//   perf_tail    write pointer, zero-extended to 8 bits
//   perf_full    {7'b0, full}
//   perf_reload  {7'b0, reload_q}, one-cycle-delayed copy of flush
module instrs_buff #(
  parameter int DEPTH      = 8,
  parameter int DATA_WIDTH = 32,
  parameter int PC_WIDTH   = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_instr,
  input  logic [PC_WIDTH-1:0]   in_pc,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_instr,
  output logic [PC_WIDTH-1:0]   out_pc,
  output logic [7:0]            perf_head,
  output logic [7:0]            perf_tail,
  output logic [7:0]            perf_full,
  output logic [7:0]            perf_reload
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0]      head;
  logic [PTR_W-1:0]      tail;
  logic [CNT_W-1:0]      count;
  logic                  reload_q;
  logic                  full;
  logic                  empty;
  logic                  push;
  logic                  pop;

  logic [DATA_WIDTH-1:0] instr_mem [DEPTH];
  logic [PC_WIDTH-1:0]   pc_mem    [DEPTH];

  // Occupancy flags and handshakes. Flush and reset both block traffic in
  // the same cycle so nothing slips in or out while the buffer is emptied.
  assign full      = (count == CNT_W'(DEPTH));
  assign empty     = (count == '0);
  assign in_ready  = !full && !flush && !rst;
  assign out_valid = !empty && !flush && !rst;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Head entry is read combinationally; no bypass from the write port.
  assign out_instr = instr_mem[head];
  assign out_pc    = pc_mem[head];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      reload_q <= 1'b0;
    end else begin
      reload_q <= flush;
      if (flush) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (push) tail <= tail + PTR_W'(1);
        if (pop)  head <= head + PTR_W'(1);
        case ({push, pop})
          2'b10:   count <= count + CNT_W'(1);
          2'b01:   count <= count - CNT_W'(1);
          default: count <= count;
        endcase
      end
    end
  end

  // Storage has no reset; push already excludes flush and reset cycles.
  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[tail] <= in_instr;
      pc_mem[tail]    <= in_pc;
    end
  end

  assign perf_head   = {{(8-PTR_W){1'b0}}, head};
  assign perf_tail   = {{(8-PTR_W){1'b0}}, tail};
  assign perf_full   = {7'b0, full};
  assign perf_reload = {7'b0, reload_q};

  // Structural invariants of the ring.
  a_count_range: assert property (@(posedge clk) disable iff (rst)
    count <= CNT_W'(DEPTH));
  a_ptr_count: assert property (@(posedge clk) disable iff (rst)
    (tail - head) == count[PTR_W-1:0]);
  a_no_push_full: assert property (@(posedge clk) disable iff (rst)
    !(push && full));
  a_no_pop_empty: assert property (@(posedge clk) disable iff (rst)
    !(pop && empty));

endmodule

// File: doc/instrs_buff.md
Name: instrs_buff

Overview:
- Circular instruction FIFO between the fetch stage and the decoder.
- Holds fetched instruction/PC pairs, decouples fetch stalls from decode stalls, and empties on a pipeline reload (flush).
- Drives the four 8-bit perf signals (head, tail, full, reload) consumed by the simulation instruction-buffer perf monitor.

Parameters:
- DEPTH, 8, number of entries; power of two, 2..128.
- DATA_WIDTH, 32, instruction width.
- PC_WIDTH, 32, PC width.
- Derived: PTR_W = log2(DEPTH).

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  reset; synchronous, active-high.
- flush  input  1  pipeline reload; empties the buffer.
- in_valid  input  1  fetch offers an entry.
- in_ready  output  1  buffer accepts an entry.
- in_instr  input  DATA_WIDTH  fetched instruction.
- in_pc  input  PC_WIDTH  PC of the fetched instruction.
- out_valid  output  1  head entry available to decode.
- out_ready  input  1  decode consumes the head entry.
- out_instr  output  DATA_WIDTH  instruction at head.
- out_pc  output  PC_WIDTH  PC at head.
- perf_head  output  8  read pointer, zero-extended.
- perf_tail  output  8  write pointer, zero-extended.
- perf_full  output  8  {7'b0, full}.
- perf_reload  output  8  {7'b0, reload_q}.

Behaviour:
- State:
  - head and tail pointers, PTR_W bits each.
  - count, PTR_W+1 bits.
  - reload_q, 1 bit.
  - storage array; storage is not reset.
- Derived flags: full = (count == DEPTH); empty = (count == 0).
- Reset (rst high at a clock edge):
  - head, tail, count and reload_q go to 0.
  - While rst is high, in_ready = 0 and out_valid = 0.
  - After reset: perf_head = perf_tail = perf_full = perf_reload = 0 and in_ready = 1.
  - Reset mid-operation discards all entries; no output pulses.
- Handshake:
  - push = in_valid & in_ready; pop = out_valid & out_ready.
  - in_ready = !full & !flush & !rst.
  - out_valid = !empty & !flush & !rst.
  - out_instr and out_pc are combinational reads of storage[head]. Their value is don't-care when out_valid = 0.
- Push: writes storage[tail]; tail advances by 1 and wraps from DEPTH-1 to 0.
- Pop: head advances by 1 with the same wrap.
- Count update:
  - push and no pop: +1.
  - pop and no push: -1.
  - both: unchanged, with both pointers advancing.
- Latency: no bypass. An entry pushed at cycle N can first appear on out_valid at cycle N+1.
- Empty buffer: out_valid = 0, so push and pop cannot both occur in that cycle.
- Full buffer: in_ready = 0, even when out_ready = 1; no push-through when full. The pop proceeds, and in_ready rises the next cycle.
- Flush has highest priority:
  - In the flush cycle, no push and no pop take effect.
  - Next cycle: head = tail = count = 0.
  - reload_q is set to 1 in the cycle after flush and cleared when flush is not asserted.
  - Asserting flush for k consecutive cycles gives perf_reload = 1 for k cycles, each delayed by one cycle.
- Flush while empty: same behaviour; the pointers still reset to 0.
- Perf outputs:
  - perf_head and perf_tail are the pointer registers directly, reflecting the state after the last edge.
  - perf_full is combinational from count.
  - All perf outputs are stable for the whole cycle and sampled by the monitor at posedge while rst is low.
- Assertions:
  - count <= DEPTH.
  - (tail - head) mod DEPTH == count mod DEPTH.
  - No push when full; no pop when empty.

Test Plan:
- Reset, then idle: after rst deasserts → in_ready = 1, out_valid = 0, all perf outputs 0.
- Fill without consuming (DEPTH = 8, out_ready = 0, push PCs 0x100, 0x104, …, 8 cycles):
  - in_ready drops after the 8th push.
  - perf_full = 1, perf_tail = 0 (wrapped), perf_head = 0.
  - out_pc = 0x100.
- Drain after fill (out_ready = 1, in_valid = 0): out_pc sequence 0x100 .. 0x11C over 8 cycles, then out_valid = 0 and perf_head = 0.
- Simultaneous push/pop at count = 3: count stays 3, both perf_head and perf_tail advance by 1 per cycle. Run 10 cycles so the pointers wrap 7→0 with no data loss; check FIFO order of PCs.
- Full with out_ready = 1 and in_valid = 1: in_ready stays 0 in that cycle, one pop occurs, next cycle in_ready = 1 and perf_full = 0.
- Flush with 5 entries and in_valid = 1 in the same cycle:
  - The flush-cycle entry is dropped.
  - Next cycle: out_valid = 0, perf_head = perf_tail = 0, perf_reload = 1.
  - The following cycle, with flush low: perf_reload = 0.
  - A new push of 0x200 is visible on out_pc one cycle after it is accepted.
